// File: rtl/id_hazard_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// id_hazard_ctrl
//   Stall/flush controller for the decode stage of the 5-stage pipeline.
//   A small shift-register scoreboard tracks the destination registers of
//   instructions in flight in EX (slot0), MEM (slot1) and WB (slot2). A decoded
//   instruction that reads a register still pending in the scoreboard is held
//   in ID while bubbles go into ID/EX. A taken branch in EX flushes IF/ID and
//   bubbles ID/EX. A decoded createdump drains the pipe for SB_DEPTH+1 cycles
//   and then freezes it until reset.
//
// Ports
//   clk              pipeline clock
//   rst              asynchronous reset, active low
//   id_valid         IF/ID holds a real instruction
//   id_rs, id_rt     decode source register specifiers
//   id_rs_used       instruction reads rs
//   id_rt_used       instruction reads rt
//   id_reg_w_en      instruction writes a register
//   id_dest          destination specifier (R7 for JAL/JALR)
//   id_createdump    decoded HALT/createdump
//   ex_branch_taken  EX resolved a redirect
//   pc_en            PC write enable
//   if_id_en         IF/ID latch enable
//   if_id_flush      load a NOP into IF/ID
//   id_ex_en         ID/EX latch enable
//   id_ex_bubble     zero all ID/EX control bits
//   halted           pipeline frozen after the createdump has drained
// -----------------------------------------------------------------------------
module id_hazard_ctrl #(
   parameter int REG_BITS  = 3,
   parameter int SB_DEPTH  = 3,
   parameter bit WB_BYPASS = 1'b0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                id_valid,
   input  logic [REG_BITS-1:0] id_rs,
   input  logic [REG_BITS-1:0] id_rt,
   input  logic                id_rs_used,
   input  logic                id_rt_used,
   input  logic                id_reg_w_en,
   input  logic [REG_BITS-1:0] id_dest,
   input  logic                id_createdump,
   input  logic                ex_branch_taken,
   output logic                pc_en,
   output logic                if_id_en,
   output logic                if_id_flush,
   output logic                id_ex_en,
   output logic                id_ex_bubble,
   output logic                halted
);

   // With a write-through register file the WB slot is already visible to
   // decode, so only the slots ahead of it can cause a hazard.
   localparam int CMP_DEPTH = WB_BYPASS ? SB_DEPTH - 1 : SB_DEPTH;
   localparam int CNT_BITS  = $clog2(SB_DEPTH + 1);

   typedef enum logic [1:0] {
      S_RUN,
      S_DRAIN,
      S_HALTED
   } state_t;

   state_t              state;
   logic [CNT_BITS-1:0] drain_cnt;

   logic [SB_DEPTH-1:0] sb_v;
   logic [REG_BITS-1:0] sb_dest [SB_DEPTH];

   logic in_run;
   logic halting;
   logic hit_rs;
   logic hit_rt;
   logic stall;
   logic flush;
   logic sb_load;
   logic start_dump;

   // Scoreboard compare on pre-edge contents: a producer leaving a compared
   // slot at this edge still holds the consumer for this cycle.
   always_comb begin
      // NOTE: every combinational output gets a default first, so no path
      // through the block leaves it unassigned and no latch is inferred.
      hit_rs = 1'b0;
      hit_rt = 1'b0;
      for (int k = 0; k < CMP_DEPTH; k++) begin
         if (sb_v[k] && (sb_dest[k] == id_rs)) hit_rs = 1'b1;
         if (sb_v[k] && (sb_dest[k] == id_rt)) hit_rt = 1'b1;
      end
      hit_rs = hit_rs & id_rs_used;
      hit_rt = hit_rt & id_rt_used;
   end

   assign in_run  = (state == S_RUN);
   assign halting = ~in_run;

   // Redirects are only honoured in RUN: while draining, the dump is the
   // youngest instruction past ID, so nothing in EX can legitimately branch.
   // Gating with rst keeps every control strobe quiet while reset is held.
   assign flush = rst & in_run & ex_branch_taken;
   assign stall = rst & in_run & id_valid & (hit_rs | hit_rt) & ~ex_branch_taken;

   assign sb_load    = id_valid & id_reg_w_en & ~stall & ~flush & ~halting;
   assign start_dump = in_run & id_valid & id_createdump & ~stall & ~flush;

   // Pipeline enables follow the current state and hazard the same cycle.
   always_comb begin
      pc_en        = 1'b1;
      if_id_en     = 1'b1;
      if_id_flush  = 1'b0;
      id_ex_en     = 1'b1;
      id_ex_bubble = 1'b0;
      halted       = 1'b0;
      case (state)
         S_RUN: begin
            if (flush) begin
               if_id_flush  = 1'b1;
               id_ex_bubble = 1'b1;
            end else if (stall) begin
               pc_en        = 1'b0;
               if_id_en     = 1'b0;
               id_ex_bubble = 1'b1;
            end
         end
         S_DRAIN: begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_bubble = 1'b1;
         end
         S_HALTED: begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            id_ex_bubble = 1'b1;
            halted       = 1'b1;
         end
         default: begin
            pc_en    = 1'b1;
            if_id_en = 1'b1;
         end
      endcase
   end

   // Valid bits and the halt sequencer.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= S_RUN;
         drain_cnt <= '0;
         sb_v      <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every
         // register samples pre-edge values, which is what makes the shift work.
         sb_v <= {sb_v[SB_DEPTH-2:0], sb_load};
         case (state)
            S_RUN: begin
               if (start_dump) begin
                  state     <= S_DRAIN;
                  drain_cnt <= '0;
               end
            end
            S_DRAIN: begin
               if (drain_cnt == CNT_BITS'(SB_DEPTH)) begin
                  state <= S_HALTED;
               end else begin
                  drain_cnt <= drain_cnt + 1'b1;
               end
            end
            S_HALTED: begin
               state <= S_HALTED;
            end
            default: begin
               state <= S_RUN;
            end
         endcase
      end
   end

   // NOTE: the destination fields are not reset; a slot's dest is only
   // looked at when its valid bit is set, and the valid bits are reset.
   always_ff @(posedge clk) begin
      sb_dest[0] <= id_dest;
      for (int k = 1; k < SB_DEPTH; k++) begin
         sb_dest[k] <= sb_dest[k-1];
      end
   end

endmodule

// File: tb/tb_id_hazard_ctrl.sv
`timescale 1ns/1ps
// Self-checking bench for id_hazard_ctrl. Two instances share the stimulus:
// u_dut0 with WB_BYPASS=0 and u_dut1 with WB_BYPASS=1. The reference model
// keeps, per instance, the cycle at which each register was last issued as a
// destination and the cycle at which a createdump was issued; hazards and
// halt progress are derived from cycle distances.
module tb_id_hazard_ctrl;

   localparam int SB = 3;

   logic       clk = 1'b0;
   logic       rst;
   logic       id_valid;
   logic [2:0] id_rs;
   logic [2:0] id_rt;
   logic       id_rs_used;
   logic       id_rt_used;
   logic       id_reg_w_en;
   logic [2:0] id_dest;
   logic       id_createdump;
   logic       ex_branch_taken;

   logic [1:0] pc_en;
   logic [1:0] if_id_en;
   logic [1:0] if_id_flush;
   logic [1:0] id_ex_en;
   logic [1:0] id_ex_bubble;
   logic [1:0] halted;

   // Outputs sampled at the last negedge by tick().
   logic [1:0] s_pc;
   logic [1:0] s_flush;
   logic [1:0] s_bub;
   logic [1:0] s_exen;
   logic [1:0] s_halt;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state.
   int now = 0;
   int last_wr [2][8];
   int dump_at [2];
   int win     [2] = '{3, 2};

   always #5 clk = ~clk;

   id_hazard_ctrl #(.REG_BITS(3), .SB_DEPTH(SB), .WB_BYPASS(1'b0)) u_dut0 (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_reg_w_en(id_reg_w_en),
      .id_dest(id_dest), .id_createdump(id_createdump), .ex_branch_taken(ex_branch_taken),
      .pc_en(pc_en[0]), .if_id_en(if_id_en[0]), .if_id_flush(if_id_flush[0]),
      .id_ex_en(id_ex_en[0]), .id_ex_bubble(id_ex_bubble[0]), .halted(halted[0])
   );

   id_hazard_ctrl #(.REG_BITS(3), .SB_DEPTH(SB), .WB_BYPASS(1'b1)) u_dut1 (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_reg_w_en(id_reg_w_en),
      .id_dest(id_dest), .id_createdump(id_createdump), .ex_branch_taken(ex_branch_taken),
      .pc_en(pc_en[1]), .if_id_en(if_id_en[1]), .if_id_flush(if_id_flush[1]),
      .id_ex_en(id_ex_en[1]), .id_ex_bubble(id_ex_bubble[1]), .halted(halted[1])
   );

   task automatic check(input string tag, input int got, input int exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0d, expected %0d", tag, now, got, exp);
      end
   endtask

   task automatic drive(input bit v, input int rs, input int rt, input bit rsu,
                        input bit rtu, input bit wen, input int dest,
                        input bit dump, input bit br);
      id_valid        = v;
      id_rs           = 3'(rs);
      id_rt           = 3'(rt);
      id_rs_used      = rsu;
      id_rt_used      = rtu;
      id_reg_w_en     = wen;
      id_dest         = 3'(dest);
      id_createdump   = dump;
      ex_branch_taken = br;
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         for (int r = 0; r < 8; r++) last_wr[i][r] = -1000;
         dump_at[i] = -1;
      end
   endtask

   // 0 = running, 1 = draining, 2 = halted
   function automatic int mode_of(input int i);
      if (dump_at[i] < 0) return 0;
      if (now - dump_at[i] <= SB + 1) return 1;
      return 2;
   endfunction

   function automatic bit pending(input int i, input int r);
      int d;
      d = now - last_wr[i][r];
      return (d >= 1) && (d <= win[i]);
   endfunction

   // Called shortly after a posedge; pulses reset inside the cycle and checks
   // the outputs while it is held.
   task automatic pulse_reset();
      rst = 1'b0;
      #2;
      for (int i = 0; i < 2; i++) begin
         check($sformatf("rst_pc_en/u%0d", i),       pc_en[i],        1);
         check($sformatf("rst_if_id_en/u%0d", i),    if_id_en[i],     1);
         check($sformatf("rst_if_id_flush/u%0d", i), if_id_flush[i],  0);
         check($sformatf("rst_id_ex_en/u%0d", i),    id_ex_en[i],     1);
         check($sformatf("rst_bubble/u%0d", i),      id_ex_bubble[i], 0);
         check($sformatf("rst_halted/u%0d", i),      halted[i],       0);
      end
      rst = 1'b1;
      model_reset();
      #1;
   endtask

   // One pipeline cycle: compare at negedge, advance the model at posedge.
   task automatic tick();
      bit iss [2];
      bit dmp [2];
      @(negedge clk);
      s_pc    = pc_en;
      s_flush = if_id_flush;
      s_bub   = id_ex_bubble;
      s_exen  = id_ex_en;
      s_halt  = halted;
      for (int i = 0; i < 2; i++) begin
         int m;
         bit haz, fl, st;
         int ep, ei, ef, ee, eb, eh;
         m   = mode_of(i);
         haz = (id_rs_used && pending(i, int'(id_rs))) ||
               (id_rt_used && pending(i, int'(id_rt)));
         fl  = (m == 0) && ex_branch_taken;
         st  = (m == 0) && id_valid && haz && !ex_branch_taken;
         if (m == 2)      begin ep = 0; ei = 0; ef = 0; ee = 0; eb = 1; eh = 1; end
         else if (m == 1) begin ep = 0; ei = 0; ef = 0; ee = 1; eb = 1; eh = 0; end
         else if (fl)     begin ep = 1; ei = 1; ef = 1; ee = 1; eb = 1; eh = 0; end
         else if (st)     begin ep = 0; ei = 0; ef = 0; ee = 1; eb = 1; eh = 0; end
         else             begin ep = 1; ei = 1; ef = 0; ee = 1; eb = 0; eh = 0; end
         check($sformatf("pc_en/u%0d", i),       pc_en[i],        ep);
         check($sformatf("if_id_en/u%0d", i),    if_id_en[i],     ei);
         check($sformatf("if_id_flush/u%0d", i), if_id_flush[i],  ef);
         check($sformatf("id_ex_en/u%0d", i),    id_ex_en[i],     ee);
         check($sformatf("id_ex_bubble/u%0d", i), id_ex_bubble[i], eb);
         check($sformatf("halted/u%0d", i),      halted[i],       eh);
         iss[i] = (m == 0) && id_valid && id_reg_w_en && !st && !fl;
         dmp[i] = (m == 0) && id_valid && id_createdump && !st && !fl;
      end
      @(posedge clk);
      for (int i = 0; i < 2; i++) begin
         if (iss[i]) last_wr[i][id_dest] = now;
         if (dmp[i]) dump_at[i] = now;
      end
      now++;
      #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int c0, c1, cb, dr, hold;
      rst = 1'b0;
      model_reset();
      drive(1, 1, 1, 1, 1, 1, 1, 0, 1);
      repeat (2) @(posedge clk);
      #1;
      pulse_reset();

      // 1: back-to-back RAW on r1
      drive(1, 0, 0, 0, 0, 1, 1, 0, 0); tick();
      drive(1, 1, 3, 1, 1, 1, 2, 0, 0);
      c0 = 0; c1 = 0; cb = 0;
      repeat (6) begin
         tick();
         c0 += int'(!s_pc[0]);
         c1 += int'(!s_pc[1]);
         cb += int'(s_bub[0]);
      end
      check("t1_stall_cycles/u0", c0, 3);
      check("t1_stall_cycles/u1", c1, 2);
      check("t1_bubbles/u0", cb, 3);

      // 2: one independent op between producer and consumer
      pulse_reset();
      drive(1, 0, 0, 0, 0, 1, 1, 0, 0); tick();
      drive(1, 5, 6, 1, 1, 1, 4, 0, 0); tick();
      drive(1, 1, 0, 1, 0, 0, 0, 0, 0);
      c0 = 0; c1 = 0;
      repeat (5) begin
         tick();
         c0 += int'(!s_pc[0]);
         c1 += int'(!s_pc[1]);
      end
      check("t2_stall_cycles/u0", c0, 2);
      check("t2_stall_cycles/u1", c1, 1);

      // 3: redirect during a stall
      pulse_reset();
      drive(1, 0, 0, 0, 0, 1, 1, 0, 0); tick();
      drive(1, 1, 0, 1, 0, 1, 2, 0, 0); tick();
      check("t3_stalled", s_pc[0], 0);
      drive(1, 1, 0, 1, 0, 1, 2, 0, 1); tick();
      check("t3_flush", s_flush[0], 1);
      check("t3_bubble", s_bub[0], 1);
      check("t3_pc_en", s_pc[0], 1);
      drive(0, 1, 0, 1, 0, 0, 0, 0, 0); tick();
      check("t3_no_stall_after", s_pc[0], 1);

      // 4: unused source ignored; JAL destination R7 tracked
      pulse_reset();
      drive(1, 0, 0, 0, 0, 1, 1, 0, 0); tick();
      drive(1, 1, 2, 0, 1, 1, 3, 0, 0); tick();
      check("t4_unused_rs", s_pc[0], 1);
      drive(1, 0, 0, 0, 0, 1, 7, 0, 0); tick();
      drive(1, 7, 0, 1, 0, 1, 5, 0, 0); tick();
      check("t4_jal_r7", s_pc[0], 0);

      // 5: createdump drains then freezes; redirects ignored meanwhile
      pulse_reset();
      drive(1, 0, 0, 0, 0, 0, 0, 1, 0); tick();
      dr = 0;
      for (int k = 0; k < 20; k++) begin
         drive(0, 0, 0, 0, 0, 0, 0, 0, 1'($urandom_range(1, 0)));
         tick();
         if (s_halt[0]) break;
         dr += int'(!s_pc[0]);
      end
      check("t5_drain_cycles", dr, SB + 1);
      hold = 0;
      repeat (20) begin
         drive(1, $urandom_range(7, 0), 0, 1, 0, 1, 1, 0, 0);
         tick();
         hold += int'(s_halt[0] && !s_exen[0]);
      end
      check("t5_halted_hold", hold, 20);

      // 6: reset in the middle of a drain
      pulse_reset();
      drive(1, 0, 0, 0, 0, 1, 1, 0, 0); tick();
      drive(1, 0, 0, 0, 0, 0, 0, 1, 0); tick();
      pulse_reset();
      drive(1, 1, 0, 1, 0, 1, 2, 0, 0); tick();
      check("t6_pc_en_after_reset", s_pc[0], 1);
      check("t6_halted_after_reset", s_halt[0], 0);

      // Randomized traffic
      for (int n = 0; n < 3000; n++) begin
         if (($urandom_range(149, 0) == 0) ||
             ((s_halt == 2'b11) && ($urandom_range(9, 0) == 0)))
            pulse_reset();
         drive(1'($urandom_range(3, 0) != 0), $urandom_range(7, 0), $urandom_range(7, 0),
               1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
               $urandom_range(7, 0), 1'($urandom_range(63, 0) == 0),
               1'($urandom_range(7, 0) == 0));
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
